// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Brief    : Arbitrates ALU results and buffered load results onto the single
//            register-file write port; tracks pending loads for decode hazards.
// Revision : 1.0
// ============================================================================
module writeback_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 5,
    parameter int NUM_REGS    = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [INDEX_WIDTH-1:0] alu_index,
    input  logic [DATA_WIDTH-1:0]  alu_data,
    output logic                   alu_stall,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [INDEX_WIDTH-1:0] mem_index,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    input  logic                   issue_load,
    input  logic [INDEX_WIDTH-1:0] issue_index,
    input  logic [INDEX_WIDTH-1:0] rs1_index,
    input  logic [INDEX_WIDTH-1:0] rs2_index,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   hazard,
    output logic                   protocol_err,
    output logic [INDEX_WIDTH-1:0] write_index,
    output logic [DATA_WIDTH-1:0]  write_data,
    output logic                   DEST_REG_WRITE_ENABLE
);

    localparam int                 C_PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int                 C_CNT_W   = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(QUEUE_DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

    logic [INDEX_WIDTH-1:0] r_q_index [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]  r_q_data  [QUEUE_DEPTH];
    logic [C_PTR_W-1:0]     r_wr_ptr;
    logic [C_PTR_W-1:0]     r_rd_ptr;
    logic [C_CNT_W-1:0]     r_count;
    logic                   r_src_fifo;
    logic [NUM_REGS-1:0]    r_pending;

    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_alu_grant;

    // Flow control comes only from the registered count, never from this cycle's pop.
    assign alu_stall   = (r_count == C_DEPTH);
    assign mem_ready   = (r_count < C_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_push      = mem_valid && mem_ready;
    assign w_pop       = (alu_stall || !alu_valid) && !w_empty;
    assign w_alu_grant = alu_valid && !alu_stall;

    assign hazard = r_pending[rs1_index] | r_pending[rs2_index] | r_pending[rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_q_index[r_wr_ptr] <= mem_index;
                r_q_data[r_wr_ptr]  <= mem_data;
                r_wr_ptr            <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_index           <= '0;
            write_data            <= '0;
            DEST_REG_WRITE_ENABLE <= 1'b0;
            r_src_fifo            <= 1'b0;
        end else if (w_pop) begin
            write_index           <= r_q_index[r_rd_ptr];
            write_data            <= r_q_data[r_rd_ptr];
            DEST_REG_WRITE_ENABLE <= 1'b1;
            r_src_fifo            <= 1'b1;
        end else if (w_alu_grant) begin
            write_index           <= alu_index;
            write_data            <= alu_data;
            DEST_REG_WRITE_ENABLE <= 1'b1;
            r_src_fifo            <= 1'b0;
        end else begin
            DEST_REG_WRITE_ENABLE <= 1'b0;
            r_src_fifo            <= 1'b0;
        end
    end

    // Clear on the register-file commit edge of a load write; a same-edge issue wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (DEST_REG_WRITE_ENABLE && r_src_fifo) begin
                r_pending[write_index] <= 1'b0;
            end
            if (issue_load) begin
                r_pending[issue_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if (alu_valid && alu_stall) begin
            protocol_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit
// Brief    : Self-checking bench for writeback_unit (vector table, directed
//            corner sequences, randomized run against a queue-based model).
// Revision : 1.0
// ============================================================================
module tb_writeback_unit;

    localparam int DW = 16;
    localparam int IW = 5;
    localparam int NR = 32;
    localparam int QD = 4;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [IW-1:0] alu_index;
    logic [DW-1:0] alu_data;
    logic          alu_stall;
    logic          mem_valid;
    logic          mem_ready;
    logic [IW-1:0] mem_index;
    logic [DW-1:0] mem_data;
    logic          issue_load;
    logic [IW-1:0] issue_index;
    logic [IW-1:0] rs1_index;
    logic [IW-1:0] rs2_index;
    logic [IW-1:0] rd_index;
    logic          hazard;
    logic          protocol_err;
    logic [IW-1:0] write_index;
    logic [DW-1:0] write_data;
    logic          we;

    writeback_unit #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW),
        .NUM_REGS   (NR),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .alu_valid            (alu_valid),
        .alu_index            (alu_index),
        .alu_data             (alu_data),
        .alu_stall            (alu_stall),
        .mem_valid            (mem_valid),
        .mem_ready            (mem_ready),
        .mem_index            (mem_index),
        .mem_data             (mem_data),
        .issue_load           (issue_load),
        .issue_index          (issue_index),
        .rs1_index            (rs1_index),
        .rs2_index            (rs2_index),
        .rd_index             (rd_index),
        .hazard               (hazard),
        .protocol_err         (protocol_err),
        .write_index          (write_index),
        .write_data           (write_data),
        .DEST_REG_WRITE_ENABLE(we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of pending load results, a pending-bit array
    // and the expected contents of the registered write port.
    typedef struct {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mq[$];
    bit            m_pend[NR];
    bit            m_we;
    bit            m_src;
    bit            m_perr;
    logic [IW-1:0] m_wi;
    logic [DW-1:0] m_wd;

    task automatic model_reset();
        mq.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_we   = 1'b0;
        m_src  = 1'b0;
        m_perr = 1'b0;
        m_wi   = '0;
        m_wd   = '0;
    endtask

    task automatic model_check();
        chk("m_we",     32'(we),           32'(m_we));
        chk("m_widx",   32'(write_index),  32'(m_wi));
        chk("m_wdata",  32'(write_data),   32'(m_wd));
        chk("m_stall",  32'(alu_stall),    32'(mq.size() == QD));
        chk("m_ready",  32'(mem_ready),    32'(mq.size() < QD));
        chk("m_hazard", 32'(hazard),
            32'(m_pend[rs1_index] | m_pend[rs2_index] | m_pend[rd_index]));
        chk("m_perr",   32'(protocol_err), 32'(m_perr));
    endtask

    task automatic model_step();
        bit     full;
        bit     ready;
        entry_t e;
        if (rst) begin
            model_reset();
        end else begin
            full  = (mq.size() == QD);
            ready = (mq.size() < QD);
            if (m_we && m_src) m_pend[m_wi] = 1'b0;
            if (issue_load) m_pend[issue_index] = 1'b1;
            if (alu_valid && full) m_perr = 1'b1;
            if ((full || !alu_valid) && mq.size() > 0) begin
                e     = mq.pop_front();
                m_we  = 1'b1;
                m_src = 1'b1;
                m_wi  = e.idx;
                m_wd  = e.data;
            end else if (alu_valid) begin
                m_we  = 1'b1;
                m_src = 1'b0;
                m_wi  = alu_index;
                m_wd  = alu_data;
            end else begin
                m_we  = 1'b0;
                m_src = 1'b0;
            end
            if (mem_valid && ready) begin
                e.idx  = mem_index;
                e.data = mem_data;
                mq.push_back(e);
            end
        end
    endtask

    // Inputs change just after the rising edge; checks run at the falling edge.
    task automatic half(input bit do_chk);
        @(negedge clk);
        if (do_chk) model_check();
    endtask

    task automatic fin();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        alu_valid   = 1'b0;
        alu_index   = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_index   = '0;
        mem_data    = '0;
        issue_load  = 1'b0;
        issue_index = '0;
        rs1_index   = '0;
        rs2_index   = '0;
        rd_index    = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        half(1'b0); fin();
        half(1'b0); fin();
        rst = 1'b0;
    endtask

    typedef struct {
        bit            av;
        logic [IW-1:0] ai;
        logic [DW-1:0] ad;
        bit            mv;
        logic [IW-1:0] mi;
        logic [DW-1:0] md;
        bit            il;
        logic [IW-1:0] ii;
        logic [IW-1:0] r1;
        bit            e_we;
        logic [IW-1:0] e_wi;
        logic [DW-1:0] e_wd;
        bit            e_haz;
        bit            e_stall;
        bit            e_ready;
    } vec_t;

    function automatic vec_t row(input bit av, input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                                 input bit mv, input logic [IW-1:0] mi, input logic [DW-1:0] md,
                                 input bit il, input logic [IW-1:0] ii, input logic [IW-1:0] r1,
                                 input bit ewe, input logic [IW-1:0] ewi, input logic [DW-1:0] ewd,
                                 input bit ehz, input bit est, input bit erd);
        vec_t v;
        v.av = av; v.ai = ai; v.ad = ad;
        v.mv = mv; v.mi = mi; v.md = md;
        v.il = il; v.ii = ii; v.r1 = r1;
        v.e_we = ewe; v.e_wi = ewi; v.e_wd = ewd;
        v.e_haz = ehz; v.e_stall = est; v.e_ready = erd;
        return v;
    endfunction

    vec_t          tbl[11];
    logic [IW-1:0] drain_idx[4];
    logic [DW-1:0] drain_dat[4];

    initial begin
        rst = 1'b1;
        model_reset();
        do_reset();

        // Single ALU write followed by a load round trip on r7.
        tbl[0]  = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tbl[1]  = row(1'b1, 5'd3, 16'h1234, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tbl[2]  = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 16'h1234, 1'b0, 1'b0, 1'b1);
        tbl[3]  = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 16'h1234, 1'b0, 1'b0, 1'b1);
        tbl[4]  = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 16'h1234, 1'b0, 1'b0, 1'b1);
        tbl[5]  = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd7, 1'b0, 5'd3, 16'h1234, 1'b1, 1'b0, 1'b1);
        tbl[6]  = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd7, 1'b0, 5'd3, 16'h1234, 1'b1, 1'b0, 1'b1);
        tbl[7]  = row(1'b0, 5'd0, 16'h0000, 1'b1, 5'd7, 16'hA5A5, 1'b0, 5'd0, 5'd7, 1'b0, 5'd3, 16'h1234, 1'b1, 1'b0, 1'b1);
        tbl[8]  = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd7, 1'b0, 5'd3, 16'h1234, 1'b1, 1'b0, 1'b1);
        tbl[9]  = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd7, 1'b1, 5'd7, 16'hA5A5, 1'b1, 1'b0, 1'b1);
        tbl[10] = row(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd7, 1'b0, 5'd7, 16'hA5A5, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 11; i++) begin
            set_idle();
            alu_valid   = tbl[i].av;
            alu_index   = tbl[i].ai;
            alu_data    = tbl[i].ad;
            mem_valid   = tbl[i].mv;
            mem_index   = tbl[i].mi;
            mem_data    = tbl[i].md;
            issue_load  = tbl[i].il;
            issue_index = tbl[i].ii;
            rs1_index   = tbl[i].r1;
            half(1'b1);
            chk($sformatf("tbl%0d_we", i),    32'(we),           32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_widx", i),  32'(write_index),  32'(tbl[i].e_wi));
            chk($sformatf("tbl%0d_wdata", i), 32'(write_data),   32'(tbl[i].e_wd));
            chk($sformatf("tbl%0d_hazard", i), 32'(hazard),      32'(tbl[i].e_haz));
            chk($sformatf("tbl%0d_stall", i), 32'(alu_stall),    32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_ready", i), 32'(mem_ready),    32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_perr", i),  32'(protocol_err), 32'(0));
            fin();
        end

        // ALU priority while four loads fill the FIFO, then drain in push order.
        for (int i = 0; i < 4; i++) begin
            set_idle();
            alu_valid = 1'b1;
            alu_index = IW'(1 + i);
            alu_data  = 16'h0100 + 16'(i);
            mem_valid = 1'b1;
            mem_index = IW'(10 + i);
            mem_data  = 16'hC000 + 16'(i);
            half(1'b1);
            chk("fill_stall", 32'(alu_stall), 32'(0));
            chk("fill_ready", 32'(mem_ready), 32'(1));
            if (i > 0) begin
                chk("fill_alu_we",  32'(we),          32'(1));
                chk("fill_alu_idx", 32'(write_index), 32'(i));
            end
            fin();
        end
        set_idle();
        mem_valid = 1'b1;
        mem_index = 5'd15;
        mem_data  = 16'hC004;
        half(1'b1);
        chk("full_stall", 32'(alu_stall),   32'(1));
        chk("full_ready", 32'(mem_ready),   32'(0));
        chk("full_we",    32'(we),          32'(1));
        chk("full_idx",   32'(write_index), 32'(4));
        fin();
        half(1'b1);
        chk("rise_ready", 32'(mem_ready),   32'(1));
        chk("rise_stall", 32'(alu_stall),   32'(0));
        chk("head_we",    32'(we),          32'(1));
        chk("head_idx",   32'(write_index), 32'(10));
        chk("head_data",  32'(write_data),  32'(16'hC000));
        fin();
        mem_valid = 1'b0;
        drain_idx = '{5'd11, 5'd12, 5'd13, 5'd15};
        drain_dat = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        for (int i = 0; i < 4; i++) begin
            half(1'b1);
            chk("drain_we",   32'(we),          32'(1));
            chk("drain_idx",  32'(write_index), 32'(drain_idx[i]));
            chk("drain_data", 32'(write_data),  32'(drain_dat[i]));
            fin();
        end
        half(1'b1);
        chk("drain_done", 32'(we), 32'(0));
        fin();

        // Load commit for r9 on the same edge as a new issue to r9.
        set_idle();
        rd_index    = 5'd9;
        issue_load  = 1'b1;
        issue_index = 5'd9;
        half(1'b1); fin();
        issue_load = 1'b0;
        mem_valid  = 1'b1;
        mem_index  = 5'd9;
        mem_data   = 16'h9999;
        half(1'b1);
        chk("conf_haz_pre", 32'(hazard), 32'(1));
        fin();
        mem_valid = 1'b0;
        half(1'b1); fin();
        issue_load  = 1'b1;
        issue_index = 5'd9;
        half(1'b1);
        chk("conf_we",  32'(we),          32'(1));
        chk("conf_idx", 32'(write_index), 32'(9));
        fin();
        issue_load = 1'b0;
        mem_valid  = 1'b1;
        mem_data   = 16'h8888;
        half(1'b1);
        chk("conf_haz_kept", 32'(hazard), 32'(1));
        fin();
        mem_valid = 1'b0;
        half(1'b1); fin();
        half(1'b1);
        chk("conf_we2",   32'(we),         32'(1));
        chk("conf_data2", 32'(write_data), 32'(16'h8888));
        fin();
        half(1'b1);
        chk("conf_haz_clr", 32'(hazard), 32'(0));
        fin();

        // Protocol violation on a full FIFO, then reset with three entries buffered.
        set_idle();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_index = 5'd1;
            alu_data  = 16'h1111 + 16'(i);
            mem_valid = 1'b1;
            mem_index = IW'(20 + i);
            mem_data  = 16'h7000 + 16'(i);
            half(1'b1); fin();
        end
        mem_valid = 1'b0;
        alu_index = 5'd21;
        alu_data  = 16'hDEAD;
        half(1'b1);
        chk("viol_stall", 32'(alu_stall), 32'(1));
        fin();
        alu_valid = 1'b0;
        rst       = 1'b1;
        half(1'b1);
        chk("viol_perr", 32'(protocol_err), 32'(1));
        chk("viol_we",   32'(we),           32'(1));
        chk("viol_idx",  32'(write_index),  32'(20));
        chk("viol_data", 32'(write_data),   32'(16'h7000));
        fin();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            half(1'b1);
            chk("rst_we",    32'(we),           32'(0));
            chk("rst_idx",   32'(write_index),  32'(0));
            chk("rst_data",  32'(write_data),   32'(0));
            chk("rst_perr",  32'(protocol_err), 32'(0));
            chk("rst_stall", 32'(alu_stall),    32'(0));
            chk("rst_ready", 32'(mem_ready),    32'(1));
            fin();
        end

        // Randomized traffic against the model; small index range forces collisions.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            alu_valid   = ($urandom_range(0, 1) == 1) &&
                          ((mq.size() < QD) || ($urandom_range(0, 39) == 0));
            alu_index   = IW'($urandom_range(0, 7));
            alu_data    = DW'($urandom);
            mem_valid   = ($urandom_range(0, 9) < 6);
            mem_index   = IW'($urandom_range(0, 7));
            mem_data    = DW'($urandom);
            issue_load  = ($urandom_range(0, 3) == 0);
            issue_index = IW'($urandom_range(0, 7));
            rs1_index   = IW'($urandom_range(0, 7));
            rs2_index   = IW'($urandom_range(0, 7));
            rd_index    = IW'($urandom_range(0, 7));
            half(1'b1);
            fin();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
